// File: rtl/ring_osc_meter_if.sv
`timescale 1ns/1ps
// Measurement request/result bundle between a controller and ring_osc_meter.
interface ring_osc_meter_if #(
    parameter int SEL_W  = 4,
    parameter int GATE_W = 16,
    parameter int CNT_W  = 20
);
    logic [SEL_W-1:0]  sel;
    logic [GATE_W-1:0] gate_cycles;
    logic              start;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    modport master (
        output sel, gate_cycles, start,
        input  busy, done, count, overflow
    );

    modport slave (
        input  sel, gate_cycles, start,
        output busy, done, count, overflow
    );
endinterface

// File: rtl/ring_osc_meter.sv
`timescale 1ps/1ps
// ring_osc_meter: bank of gated odd-length ring oscillators plus a frequency
// meter. The selected ring is prescaled in its own domain, synchronised into
// clk, and its rising edges are counted over a gate window of clk cycles.
module ring_osc_meter #(
    parameter int NUM_RINGS    = 9,
    parameter int MIN_STAGES   = 3,
    parameter int STAGE_STEP   = 2,
    parameter int PRESCALE     = 6,
    parameter int GATE_W       = 16,
    parameter int CNT_W        = 20,
    parameter int SEL_W        = 4,
    parameter int INV_DELAY_PS = 50
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_RINGS-1:0] ring_en,
    ring_osc_meter_if.slave      bus,
    output logic [NUM_RINGS-1:0] osc_out,
    output logic                 div_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_GATE,
        S_DONE
    } state_e;

    // Settle phase lasts three cycles: counter runs 2,1,0.
    localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(2);

    // ------------------------------------------------------------------
    // Oscillator bank. Stage 0 is the NAND that closes the loop; the other
    // stages are also gated by the enable (alternating NAND/NOR) so that a
    // disabled ring parks every node at a fixed level and always restarts
    // as a single clean wavefront. The delays only shape simulation; they
    // carry no meaning for synthesis. Rings have no reset: enable is their
    // only control.
    // ------------------------------------------------------------------
    for (genvar r = 0; r < NUM_RINGS; r++) begin : g_ring
        localparam int STAGES = MIN_STAGES + STAGE_STEP * r;
        logic [STAGES-1:0] node;

        assign #(INV_DELAY_PS) node[0] = ~(ring_en[r] & node[STAGES-1]);

        for (genvar s = 1; s < STAGES; s++) begin : g_stage
            if (s % 2 == 0) begin : g_nand
                assign #(INV_DELAY_PS) node[s] = ~(node[s-1] & ring_en[r]);
            end else begin : g_nor
                assign #(INV_DELAY_PS) node[s] = ~(node[s-1] | ~ring_en[r]);
            end
        end

        // Last node parks high when disabled, so the tap is inverted to read 0.
        assign osc_out[r] = ~node[STAGES-1];
    end

    // ------------------------------------------------------------------
    // Ring select; out-of-range selections read as a silent ring.
    // ------------------------------------------------------------------
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             mux_out;

    // Combinational mux over the latched ring index.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        mux_out = 1'b0;
        for (int i = 0; i < NUM_RINGS; i++) begin
            if (sel_q == SEL_W'(i)) begin
                mux_out = osc_out[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Ripple prescaler running in the ring's own domain.
    // ------------------------------------------------------------------
    logic [PRESCALE:0] div_clk;
    assign div_clk[0] = mux_out;

    for (genvar k = 0; k < PRESCALE; k++) begin : g_div
        logic tog_q, tog_d;

        assign tog_d = ~tog_q;

        // Toggle flop: each stage halves the frequency of the one before.
        always_ff @(posedge div_clk[k] or negedge rst_n) begin
            // NOTE: sequential state is updated with <= so every flop samples pre-edge values regardless of block order.
            if (!rst_n) begin
                tog_q <= 1'b0;
            end else begin
                tog_q <= tog_d;
            end
        end

        assign div_clk[k+1] = tog_q;
    end

    assign div_out = div_clk[PRESCALE];

    // ------------------------------------------------------------------
    // Two-flop synchroniser into clk plus a rising-edge detect flop.
    // ------------------------------------------------------------------
    logic [1:0] sync_q, sync_d;
    logic       prev_q, prev_d;
    logic       rise;

    // Next-state of the synchroniser chain.
    always_comb begin
        sync_d = {sync_q[0], div_out};
        prev_d = sync_q[1];
    end

    // Synchroniser and edge-detect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise = sync_q[1] & ~prev_q;

    // ------------------------------------------------------------------
    // Measurement sequencer.
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [GATE_W-1:0] gate_q, gate_d;
    logic [GATE_W-1:0] cyc_q, cyc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        gate_d     = gate_q;
        cyc_d      = cyc_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sel_d      = bus.sel;
                    gate_d     = bus.gate_cycles;
                    count_d    = '0;
                    overflow_d = 1'b0;
                    cyc_d      = SETTLE_LAST;
                    busy_d     = 1'b1;
                    state_d    = S_SETTLE;
                end
            end

            // Let the synchroniser and edge detector flush after a mux change.
            S_SETTLE: begin
                if (cyc_q == '0) begin
                    if (gate_q == '0) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cyc_d   = gate_q - GATE_W'(1);
                        state_d = S_GATE;
                    end
                end else begin
                    cyc_d = cyc_q - GATE_W'(1);
                end
            end

            S_GATE: begin
                if (rise) begin
                    if (count_q == '1) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                if (cyc_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cyc_d = cyc_q - GATE_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sel_q      <= '0;
            gate_q     <= '0;
            cyc_q      <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            gate_q     <= gate_d;
            cyc_q      <= cyc_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.count    = count_q;
    assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_ring_osc_meter.sv
`timescale 1ns/1ps
// Self-checking bench for ring_osc_meter: directed corner cases plus random
// ring/gate choices, compared against a frequency model of the ring bank.
module tb_ring_osc_meter;

    localparam int  NUM_RINGS    = 9;
    localparam int  MIN_STAGES   = 3;
    localparam int  STAGE_STEP   = 2;
    localparam int  PRESCALE     = 6;
    localparam int  GATE_W       = 16;
    localparam int  CNT_W        = 20;
    localparam int  CNT_W_B      = 8;
    localparam int  SEL_W        = 4;
    localparam int  INV_DELAY_PS = 50;
    localparam real TCLK_PS      = 10000.0;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NUM_RINGS-1:0] en_a, en_b, osc_a, osc_b;
    logic                 div_a, div_b;

    logic [SEL_W-1:0]     sel_drv;
    logic [GATE_W-1:0]    gate_drv;
    logic                 start_drv;
    logic                 use_b;

    int n_checks;
    int n_fail;

    ring_osc_meter_if #(.SEL_W(SEL_W), .GATE_W(GATE_W), .CNT_W(CNT_W))   ifa ();
    ring_osc_meter_if #(.SEL_W(SEL_W), .GATE_W(GATE_W), .CNT_W(CNT_W_B)) ifb ();

    assign ifa.sel         = sel_drv;
    assign ifa.gate_cycles = gate_drv;
    assign ifa.start       = start_drv & ~use_b;
    assign ifb.sel         = sel_drv;
    assign ifb.gate_cycles = gate_drv;
    assign ifb.start       = start_drv & use_b;

    ring_osc_meter #(
        .NUM_RINGS(NUM_RINGS), .MIN_STAGES(MIN_STAGES), .STAGE_STEP(STAGE_STEP),
        .PRESCALE(PRESCALE), .GATE_W(GATE_W), .CNT_W(CNT_W), .SEL_W(SEL_W),
        .INV_DELAY_PS(INV_DELAY_PS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ring_en(en_a), .bus(ifa),
        .osc_out(osc_a), .div_out(div_a)
    );

    ring_osc_meter #(
        .NUM_RINGS(NUM_RINGS), .MIN_STAGES(MIN_STAGES), .STAGE_STEP(STAGE_STEP),
        .PRESCALE(PRESCALE), .GATE_W(GATE_W), .CNT_W(CNT_W_B), .SEL_W(SEL_W),
        .INV_DELAY_PS(INV_DELAY_PS)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .ring_en(en_b), .bus(ifb),
        .osc_out(osc_b), .div_out(div_b)
    );

    // Observation view of whichever meter is under test.
    logic        obs_busy, obs_done, obs_ovf;
    logic [31:0] obs_count;
    assign obs_busy  = use_b ? ifb.busy     : ifa.busy;
    assign obs_done  = use_b ? ifb.done     : ifa.done;
    assign obs_ovf   = use_b ? ifb.overflow : ifa.overflow;
    assign obs_count = use_b ? 32'(ifb.count) : 32'(ifa.count);

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected divided-edge count from ring period: 2*stages*delay, times 2^PRESCALE.
    function automatic real model_edges(input int ring, input int gate,
                                        input logic [NUM_RINGS-1:0] en);
        real period_ps;
        if (ring >= NUM_RINGS) return 0.0;
        if (!en[ring]) return 0.0;
        period_ps = real'(2 ** PRESCALE) * 2.0 * real'(MIN_STAGES + STAGE_STEP * ring)
                    * real'(INV_DELAY_PS);
        return real'(gate) * TCLK_PS / period_ps;
    endfunction

    // One measurement on the meter chosen by use_b, checked against the model.
    task automatic run_case(input string tag, input int ring, input int gate, input bit poke);
        int  cnt, ovf, lat, busy_cyc, cnt1, ovf1, busy_at_done, extra_done, lo, hi, maxc;
        real e;
        logic [NUM_RINGS-1:0] en_now;

        en_now = use_b ? en_b : en_a;
        @(posedge clk); #1;
        sel_drv   = SEL_W'(ring);
        gate_drv  = GATE_W'(gate);
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        cnt1 = int'(obs_count);
        ovf1 = int'(obs_ovf);
        lat = 1;
        busy_cyc = 0;
        while (!obs_done && lat < gate + 64) begin
            if (obs_busy) busy_cyc++;
            if (poke && lat == 8) begin
                start_drv = 1'b1;
                sel_drv   = SEL_W'((ring + 3) % NUM_RINGS);
                gate_drv  = GATE_W'(3);
            end else if (poke && lat == 9) begin
                start_drv = 1'b0;
            end else if (poke && lat == gate / 2) begin
                sel_drv = SEL_W'((ring + 5) % NUM_RINGS);
            end
            @(posedge clk); #1;
            lat++;
        end
        cnt = int'(obs_count);
        ovf = int'(obs_ovf);
        busy_at_done = int'(obs_busy);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (obs_done) extra_done++;
        end

        check({tag, "_cleared_count"}, cnt1, 0);
        check({tag, "_cleared_ovf"}, ovf1, 0);
        check({tag, "_done_latency"}, lat, gate + 4);
        check({tag, "_busy_cycles"}, busy_cyc, gate + 3);
        check({tag, "_busy_in_done"}, busy_at_done, 0);
        check({tag, "_single_done"}, extra_done, 0);

        maxc = use_b ? (1 << CNT_W_B) - 1 : (1 << CNT_W) - 1;
        e = model_edges(ring, gate, en_now);
        if (e == 0.0) begin
            check({tag, "_count"}, cnt, 0);
            check({tag, "_ovf"}, ovf, 0);
        end else begin
            lo = int'($floor(e)) - 1;
            hi = int'($ceil(e)) + 1;
            if (lo > maxc) begin
                check({tag, "_count_sat"}, cnt, maxc);
                check({tag, "_ovf"}, ovf, 1);
            end else begin
                check($sformatf("%s_count_in[%0d..%0d]_was_%0d", tag, lo, hi, cnt),
                      longint'(cnt >= lo && cnt <= hi), 1);
                check({tag, "_ovf"}, ovf, 0);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ring, gate, pulses;

        n_checks  = 0;
        n_fail    = 0;
        use_b     = 1'b0;
        sel_drv   = '0;
        gate_drv  = '0;
        start_drv = 1'b1;
        rst_n     = 1'b0;
        en_a      = '1;
        en_b      = '1;
        #1;
        // Park every ring at its disabled level.
        en_a = '0;
        en_b = '0;
        #30;

        // Reset with start held high.
        check("rst_busy", ifa.busy, 0);
        check("rst_done", ifa.done, 0);
        check("rst_count", ifa.count, 0);
        check("rst_ovf", ifa.overflow, 0);
        check("rst_div", div_a, 0);
        check("parked_osc_a", osc_a, 0);
        check("parked_osc_b", osc_b, 0);
        check("rst_b_div", div_b, 0);
        start_drv = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_busy", ifa.busy, 0);
        check("idle_done", ifa.done, 0);

        // Slowest ring, all rings running.
        en_a = '1;
        run_case("ring8_g1000", 8, 1000, 1'b0);
        run_case("ring8_g0", 8, 0, 1'b0);

        // Disabled selected ring while the others run.
        en_a = '1;
        en_a[2] = 1'b0;
        run_case("ring2_off", 2, 200, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #3;
            check("osc2_parked", osc_a[2], 0);
        end

        // Invalid ring index.
        en_a = '1;
        run_case("sel12", 12, 200, 1'b0);

        // Random channel / window choices.
        for (int t = 0; t < 6; t++) begin
            ring = int'($urandom_range(11, 1));
            gate = int'($urandom_range(600, 40));
            en_a = '0;
            if (ring < NUM_RINGS && $urandom_range(4, 0) != 0) en_a[ring] = 1'b1;
            run_case($sformatf("rnd%0d_r%0d_g%0d", t, ring, gate), ring, gate, 1'b0);
        end

        // Start re-pulsed and sel changed while busy.
        en_a = '0;
        en_a[4] = 1'b1;
        run_case("poke_ring4", 4, 300, 1'b1);

        // Narrow counter saturates on the fastest ring; a new start clears it.
        use_b = 1'b1;
        en_b  = '0;
        en_b[0] = 1'b1;
        run_case("b_ring0_sat", 0, 1000, 1'b0);
        run_case("b_ring0_again", 0, 1000, 1'b0);
        en_b  = '0;
        use_b = 1'b0;

        // Reset in the middle of the gate window.
        en_a = '0;
        en_a[1] = 1'b1;
        @(posedge clk); #1;
        sel_drv   = SEL_W'(1);
        gate_drv  = GATE_W'(500);
        start_drv = 1'b1;
        @(posedge clk); #1;
        start_drv = 1'b0;
        repeat (150) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", ifa.busy, 0);
        check("midrst_done", ifa.done, 0);
        check("midrst_count", ifa.count, 0);
        check("midrst_ovf", ifa.overflow, 0);
        #10;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            if (ifa.done) pulses++;
        end
        check("midrst_no_done", pulses, 0);
        check("midrst_idle", ifa.busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
